// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the core memory arbiter and its ID FIFO.
//   ARB_ID_W      : ID width for the default two-port build (for tooling)
//   mem_req_t     : memory request bundle {addr, wen, wdata, wmask}
//   mem_resp_t    : memory response bundle {rdata}
package core_mem_arbiter_pkg;

    localparam int ARB_NUM_PORTS = 2;
    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_DATA_W    = 32;
    localparam int ARB_ID_W      = $clog2(ARB_NUM_PORTS);

    typedef struct packed {
        logic [ARB_ADDR_W-1:0]   addr;
        logic                    wen;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] wmask;
    } mem_req_t;

    typedef struct packed {
        logic [ARB_DATA_W-1:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/core_mem_arbiter_id_fifo.sv
// Parametrised synchronous FIFO used to remember which port owns each
// in-flight memory request. Also usable as a small fetch buffer.
//   clk, reset         : clock, synchronous active-high reset
//   push, push_data    : write an entry (ignored when full)
//   pop, pop_data      : read/remove the head entry (ignored when empty);
//                        pop_data always shows the current head
//   full, empty, count : occupancy status
module core_mem_arbiter_id_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter letting NUM_PORTS core memory ports share one memory.
// Requests are forwarded combinationally; the granting port's ID is queued
// so in-order memory responses can be routed back to their requester.
//   clk, reset                         : clock, synchronous active-high reset
//   req_valid/addr/wen/wdata/wmask     : per-port requests (flattened, port 0 in LSBs)
//   req_ready                          : one-hot accept strobe
//   resp_valid, resp_rdata             : one-hot response strobe, broadcast data
//   mem_req_*, mem_addr/wen/wdata/wmask: request to the shared memory
//   mem_resp_valid, mem_resp_rdata     : in-order memory responses
//   outstanding                        : in-flight request count
//   err_spurious                       : sticky, response seen with nothing in flight
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS       = 2,
    parameter  int ADDR_W          = 32,
    parameter  int DATA_W          = 32,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int ID_W            = $clog2(NUM_PORTS),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0]          req_wen,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_wmask,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_wen,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W/8-1:0]           mem_wmask,
    input  logic                          mem_resp_valid,
    input  logic [DATA_W-1:0]             mem_resp_rdata,
    output logic [CNT_W-1:0]              outstanding,
    output logic                          err_spurious
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [ID_W-1:0] locked_id_q, locked_id_d;
    logic            err_spurious_q, err_spurious_d;

    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] head_id;
    logic            fifo_full, fifo_empty;
    logic            accept, resp_pop;
    logic            found;
    int              idx;

    // Grant: a locked (issued but unaccepted) request keeps ownership,
    // otherwise search from rr_ptr upward with wrap-around.
    always_comb begin
        grant_id = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        if (lock_q) begin
            grant_id = locked_id_q;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = (int'(rr_ptr_q) + i) % NUM_PORTS;
                if (!found && req_valid[idx]) begin
                    grant_id = ID_W'(idx);
                    found    = 1'b1;
                end
            end
        end
    end

    // full is a registered status, so a same-cycle pop cannot open issue.
    assign mem_req_valid = (lock_q | (|req_valid)) & ~fifo_full;
    assign accept        = mem_req_valid & mem_req_ready;
    assign req_ready     = accept ? (NUM_PORTS'(1) << grant_id) : '0;

    assign mem_addr  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    assign mem_wen   = req_wen[grant_id];
    assign mem_wdata = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
    assign mem_wmask = req_wmask[int'(grant_id)*(DATA_W/8) +: (DATA_W/8)];

    assign resp_pop     = mem_resp_valid & ~fifo_empty;
    assign resp_valid   = resp_pop ? (NUM_PORTS'(1) << head_id) : '0;
    assign resp_rdata   = mem_resp_rdata;
    assign err_spurious = err_spurious_q;

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        lock_d         = lock_q;
        locked_id_d    = locked_id_q;
        err_spurious_d = err_spurious_q | (mem_resp_valid & fifo_empty);
        if (accept) begin
            rr_ptr_d = (int'(grant_id) == NUM_PORTS - 1) ? '0 : ID_W'(grant_id + 1'b1);
            lock_d   = 1'b0;
        end else if (mem_req_valid) begin
            lock_d      = 1'b1;
            locked_id_d = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            lock_q         <= 1'b0;
            locked_id_q    <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            lock_q         <= lock_d;
            locked_id_q    <= locked_id_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    core_mem_arbiter_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (grant_id),
        .pop       (resp_pop),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [1:0]  req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [1:0]  outstanding;
    logic        err_spurious;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .outstanding(outstanding),
        .err_spurious(err_spurious)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed
    // and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid      = 2'b00;
        req_wen        = 2'b00;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    initial begin
        reset     = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        idle();
        tick(); tick(); #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_outstanding", outstanding, 2'd0);
        chk("rst_err", err_spurious, 1'b0);

        // 1. single read from port 0
        tick(); reset = 1'b0;
        req_valid = 2'b01; req_addr[31:0] = 32'h100; mem_req_ready = 1'b1; #1;
        chk("t1_mem_req_valid", mem_req_valid, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_req_ready", req_ready, 2'b01);
        chk("t1_mem_wen", mem_wen, 1'b0);
        tick(); idle(); mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEADBEEF; #1;
        chk("t1_outstanding", outstanding, 2'd1);
        chk("t1_resp_valid", resp_valid, 2'b01);
        chk("t1_resp_rdata", resp_rdata, 32'hDEADBEEF);
        tick(); idle(); #1;
        chk("t1_drained", outstanding, 2'd0);

        // 2. fairness, from a fresh rr_ptr
        reset = 1'b1;
        tick(); reset = 1'b0;
        req_addr[31:0] = 32'h200; req_addr[63:32] = 32'h300;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            req_valid = 2'b11; mem_req_ready = 1'b1;
            mem_resp_valid = (k > 0); mem_resp_rdata = 32'(k); #1;
            chk("t2_req_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_mem_addr", mem_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
            chk("t2_outstanding", outstanding, (k > 0) ? 2'd1 : 2'd0);
            chk("t2_resp_valid", resp_valid,
                (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10));
        end
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("t2_last_resp", resp_valid, 2'b10);
        tick(); idle(); #1;
        chk("t2_drained", outstanding, 2'd0);

        // prime rr_ptr to port 1 so the lock is what keeps port 0 granted
        req_valid = 2'b01; req_addr[31:0] = 32'h40; mem_req_ready = 1'b1; #1;
        chk("pre_req_ready", req_ready, 2'b01);
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("pre_resp", resp_valid, 2'b01);

        // 3. stability under mem_req_ready=0
        tick(); idle();
        req_valid = 2'b01; req_addr[31:0] = 32'h400; req_addr[63:32] = 32'h500; #1;
        chk("t3_c0_valid", mem_req_valid, 1'b1);
        chk("t3_c0_addr", mem_addr, 32'h400);
        chk("t3_c0_ready", req_ready, 2'b00);
        for (int c = 1; c < 3; c++) begin
            tick(); req_valid = 2'b11; #1;
            chk("t3_locked_addr", mem_addr, 32'h400);
            chk("t3_locked_ready", req_ready, 2'b00);
        end
        tick(); mem_req_ready = 1'b1; #1;
        chk("t3_c3_addr", mem_addr, 32'h400);
        chk("t3_c3_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b10; #1;
        chk("t3_c4_addr", mem_addr, 32'h500);
        chk("t3_c4_ready", req_ready, 2'b10);
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("t3_outstanding", outstanding, 2'd2);
        chk("t3_resp0", resp_valid, 2'b01);
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("t3_resp1", resp_valid, 2'b10);
        tick(); idle(); #1;
        chk("t3_drained", outstanding, 2'd0);

        // 4. backpressure at MAX_OUTSTANDING=2
        req_valid = 2'b01; req_addr[31:0] = 32'h600; mem_req_ready = 1'b1; #1;
        chk("t4_c0_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b10; req_addr[63:32] = 32'h700; #1;
        chk("t4_c1_ready", req_ready, 2'b10);
        chk("t4_c1_outstanding", outstanding, 2'd1);
        tick(); req_valid = 2'b01; req_addr[31:0] = 32'h800; #1;
        chk("t4_full_outstanding", outstanding, 2'd2);
        chk("t4_full_valid", mem_req_valid, 1'b0);
        chk("t4_full_ready", req_ready, 2'b00);
        tick(); mem_resp_valid = 1'b1; #1;
        chk("t4_popN_resp", resp_valid, 2'b01);
        chk("t4_popN_valid", mem_req_valid, 1'b0);
        chk("t4_popN_ready", req_ready, 2'b00);
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t4_N1_outstanding", outstanding, 2'd1);
        chk("t4_N1_valid", mem_req_valid, 1'b1);
        chk("t4_N1_ready", req_ready, 2'b01);
        chk("t4_N1_addr", mem_addr, 32'h800);
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("t4_refull", outstanding, 2'd2);
        chk("t4_drain0", resp_valid, 2'b10);
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("t4_drain1", resp_valid, 2'b01);
        tick(); idle(); #1;
        chk("t4_drained", outstanding, 2'd0);

        // 5. ordering: port1 write, then port0 read
        req_valid = 2'b10; req_wen = 2'b10; req_addr[63:32] = 32'h900;
        req_wdata[63:32] = 32'hAA; req_wmask[7:4] = 4'hF; mem_req_ready = 1'b1; #1;
        chk("t5_w_ready", req_ready, 2'b10);
        chk("t5_w_wen", mem_wen, 1'b1);
        chk("t5_w_wdata", mem_wdata, 32'hAA);
        chk("t5_w_wmask", mem_wmask, 4'hF);
        tick(); req_valid = 2'b01; req_wen = 2'b00; req_addr[31:0] = 32'hA00; #1;
        chk("t5_r_ready", req_ready, 2'b01);
        chk("t5_r_wen", mem_wen, 1'b0);
        chk("t5_r_addr", mem_addr, 32'hA00);
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("t5_resp_w", resp_valid, 2'b10);
        tick(); idle(); mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55; #1;
        chk("t5_resp_r", resp_valid, 2'b01);
        chk("t5_resp_rdata", resp_rdata, 32'h55);
        tick(); idle(); #1;
        chk("t5_drained", outstanding, 2'd0);

        // 6. spurious response, then reset with two in flight
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h77; #1;
        chk("t6_spur_resp", resp_valid, 2'b00);
        tick(); idle(); #1;
        chk("t6_err_set", err_spurious, 1'b1);
        tick(); #1;
        chk("t6_err_sticky", err_spurious, 1'b1);
        req_valid = 2'b10; mem_req_ready = 1'b1; #1;
        chk("t6_a_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b01; #1;
        chk("t6_b_ready", req_ready, 2'b01);
        tick(); idle(); #1;
        chk("t6_pre_rst_outstanding", outstanding, 2'd2);
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("t6_rst_outstanding", outstanding, 2'd0);
        chk("t6_rst_err", err_spurious, 1'b0);
        req_valid = 2'b11; mem_req_ready = 1'b1; #1;
        chk("t6_rst_rr_ptr", req_ready, 2'b01);
        tick(); idle(); mem_resp_valid = 1'b1; #1;
        chk("t6_post_rst_resp", resp_valid, 2'b01);
        tick(); idle(); #1;
        chk("t6_post_rst_err", err_spurious, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
